// File: rtl/cbm2_kbd_pkg.sv
// Shared types and constants for the CBM-II keyboard matrix emulator.
// The PS/2 event record, the key position record and the hold/release state live here.
package cbm2_kbd_pkg;

  localparam int unsigned NUM_COLS = 16;
  localparam int unsigned NUM_ROWS = 6;

  typedef struct packed {
    logic       hit;
    logic [3:0] col;
    logic [2:0] row;
  } key_pos_t;

  typedef struct packed {
    logic       make;
    logic       ext;
    logic [7:0] code;
  } kbd_evt_t;

  typedef struct packed {
    logic [3:0] col;
    logic [2:0] row;
  } key_id_t;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    PENDING
  } hold_state_t;

  function automatic key_pos_t kp(input int unsigned col, input int unsigned row);
    return '{hit: 1'b1, col: 4'(col), row: 3'(row)};
  endfunction

endpackage

// File: rtl/cbm2_keymap.sv
// Registered scancode-to-matrix ROM for the CBM-II keyboard layout.
// Row 0 function/cursor keys, rows 1-4 the four typing rows, row 5 modifiers and space.
module cbm2_keymap
  import cbm2_kbd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ext,
  input  logic [7:0] code,
  output key_pos_t   pos
);

  key_pos_t pos_d;

  // NOTE: pos_d gets a default before the case, so unlisted codes cannot infer a latch.
  always_comb begin
    pos_d = '0;
    case ({ext, code})
      9'h005: pos_d = kp(1, 0);   9'h076: pos_d = kp(1, 1);   9'h00D: pos_d = kp(1, 2);
      9'h012: pos_d = kp(1, 4);   9'h014: pos_d = kp(1, 5);   9'h029: pos_d = kp(0, 5);
      9'h006: pos_d = kp(2, 0);   9'h016: pos_d = kp(2, 1);   9'h015: pos_d = kp(2, 2);
      9'h01C: pos_d = kp(2, 3);   9'h01A: pos_d = kp(2, 4);
      9'h004: pos_d = kp(3, 0);   9'h01E: pos_d = kp(3, 1);   9'h01D: pos_d = kp(3, 2);
      9'h01B: pos_d = kp(3, 3);   9'h022: pos_d = kp(3, 4);
      9'h00C: pos_d = kp(4, 0);   9'h026: pos_d = kp(4, 1);   9'h024: pos_d = kp(4, 2);
      9'h023: pos_d = kp(4, 3);   9'h021: pos_d = kp(4, 4);
      9'h003: pos_d = kp(5, 0);   9'h025: pos_d = kp(5, 1);   9'h02D: pos_d = kp(5, 2);
      9'h02B: pos_d = kp(5, 3);   9'h02A: pos_d = kp(5, 4);
      9'h00B: pos_d = kp(6, 0);   9'h02E: pos_d = kp(6, 1);   9'h02C: pos_d = kp(6, 2);
      9'h034: pos_d = kp(6, 3);   9'h032: pos_d = kp(6, 4);
      9'h083: pos_d = kp(7, 0);   9'h036: pos_d = kp(7, 1);   9'h035: pos_d = kp(7, 2);
      9'h033: pos_d = kp(7, 3);   9'h031: pos_d = kp(7, 4);
      9'h00A: pos_d = kp(8, 0);   9'h03D: pos_d = kp(8, 1);   9'h03C: pos_d = kp(8, 2);
      9'h03B: pos_d = kp(8, 3);   9'h03A: pos_d = kp(8, 4);
      9'h001: pos_d = kp(9, 0);   9'h03E: pos_d = kp(9, 1);   9'h043: pos_d = kp(9, 2);
      9'h042: pos_d = kp(9, 3);   9'h041: pos_d = kp(9, 4);
      9'h009: pos_d = kp(10, 0);  9'h046: pos_d = kp(10, 1);  9'h044: pos_d = kp(10, 2);
      9'h04B: pos_d = kp(10, 3);  9'h049: pos_d = kp(10, 4);
      9'h175: pos_d = kp(11, 0);  9'h045: pos_d = kp(11, 1);  9'h04D: pos_d = kp(11, 2);
      9'h04C: pos_d = kp(11, 3);  9'h04A: pos_d = kp(11, 4);
      9'h172: pos_d = kp(12, 0);  9'h04E: pos_d = kp(12, 1);  9'h054: pos_d = kp(12, 2);
      9'h052: pos_d = kp(12, 3);  9'h059: pos_d = kp(12, 4);
      9'h16B: pos_d = kp(13, 0);  9'h055: pos_d = kp(13, 1);  9'h05B: pos_d = kp(13, 2);
      9'h05A: pos_d = kp(13, 3);
      9'h174: pos_d = kp(14, 0);  9'h066: pos_d = kp(14, 1);  9'h05D: pos_d = kp(14, 2);
      9'h16C: pos_d = kp(15, 0);  9'h171: pos_d = kp(15, 1);  9'h170: pos_d = kp(15, 2);
      default: pos_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) pos <= '0;
    else       pos <= pos_d;
  end

endmodule

// File: rtl/cbm2_keyboard.sv
// PS/2 to CBM-II 16x6 key matrix emulator answering the keyboard TPI column scan.
// Short taps are stretched: a quick release of the newest key waits for the hold timer.
module cbm2_keyboard
  import cbm2_kbd_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 720000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [15:0] col_sel,
  output logic [5:0]  row_out,
  output logic        key_busy
);

  localparam int unsigned   TW        = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES);

  logic     tog_q, s1_valid_q, s2_valid_q, s2_make_q;
  kbd_evt_t s1_evt_q;
  key_pos_t s2_pos;

  // NOTE: all sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      tog_q      <= ps2_key[10];
      s1_valid_q <= 1'b0;
      s1_evt_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_make_q  <= 1'b0;
    end else begin
      tog_q      <= ps2_key[10];
      s1_valid_q <= ps2_key[10] ^ tog_q;
      if (ps2_key[10] ^ tog_q)
        s1_evt_q <= '{make: ps2_key[9], ext: ps2_key[8], code: ps2_key[7:0]};
      s2_valid_q <= s1_valid_q;
      s2_make_q  <= s1_evt_q.make;
    end
  end

  cbm2_keymap u_keymap (
    .clk   (clk),
    .reset (reset),
    .ext   (s1_evt_q.ext),
    .code  (s1_evt_q.code),
    .pos   (s2_pos)
  );

  logic [NUM_COLS-1:0][NUM_ROWS-1:0] mat_q, mat_d;
  logic [TW-1:0] timer_q, timer_d;
  hold_state_t   state_q, state_d;
  key_id_t       last_key_q, last_key_d, pend_key_q, pend_key_d, ev_key;
  logic [5:0]    row_d;

  always_comb begin
    mat_d      = mat_q;
    timer_d    = timer_q;
    state_d    = state_q;
    last_key_d = last_key_q;
    pend_key_d = pend_key_q;
    ev_key     = '{col: s2_pos.col, row: s2_pos.row};

    // Timer expiry is resolved first so a same-cycle event sees the post-expiry matrix.
    if (timer_q != '0) begin
      timer_d = timer_q - TW'(1);
      if (timer_d == '0) begin
        if (state_q == PENDING) mat_d[pend_key_q.col][pend_key_q.row] = 1'b0;
        state_d = IDLE;
      end
    end

    if (s2_valid_q && s2_pos.hit) begin
      if (s2_make_q) begin
        // An already-set bit is typematic repeat and must not extend the hold window.
        if (!mat_d[ev_key.col][ev_key.row]) begin
          if (state_d == PENDING) mat_d[pend_key_q.col][pend_key_q.row] = 1'b0;
          mat_d[ev_key.col][ev_key.row] = 1'b1;
          last_key_d = ev_key;
          timer_d    = HOLD_LOAD;
          state_d    = (HOLD_CYCLES > 0) ? HOLD : IDLE;
        end
      end else if (timer_d != '0 && ev_key == last_key_q) begin
        pend_key_d = ev_key;
        state_d    = PENDING;
      end else begin
        mat_d[ev_key.col][ev_key.row] = 1'b0;
      end
    end
  end

  always_comb begin
    row_d = '1;
    for (int c = 0; c < NUM_COLS; c++)
      if (!col_sel[c]) row_d = row_d & ~mat_q[c];
  end

  // NOTE: the key matrix is plain flops, not a RAM, so it is reset like any other state.
  always_ff @(posedge clk) begin
    if (reset) begin
      mat_q      <= '0;
      timer_q    <= '0;
      state_q    <= IDLE;
      last_key_q <= '0;
      pend_key_q <= '0;
      row_out    <= '1;
    end else begin
      mat_q      <= mat_d;
      timer_q    <= timer_d;
      state_q    <= state_d;
      last_key_q <= last_key_d;
      pend_key_q <= pend_key_d;
      row_out    <= row_d;
    end
  end

  assign key_busy = (state_q == PENDING);

endmodule

// File: tb/tb_cbm2_keyboard.sv
// Self-checking bench for cbm2_keyboard with a short hold time.
// Expected row/busy values are queued with their due cycle and compared on the falling edge.
module tb_cbm2_keyboard;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] ps2_key = '0;
  logic [15:0] col_sel = 16'hFFFF;
  logic [5:0]  row_out;
  logic        key_busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    string      tag;
    int         due;
    logic [5:0] row;
    logic       busy;
  } exp_t;

  exp_t sb[$];

  cbm2_keyboard #(.HOLD_CYCLES(1000)) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2_key  (ps2_key),
    .col_sel  (col_sel),
    .row_out  (row_out),
    .key_busy (key_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      check({e.tag, "_row"},  8'(row_out),  8'(e.row));
      check({e.tag, "_busy"}, 8'(key_busy), 8'(e.busy));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic expect_at(input string tag, input int due, input logic [5:0] row, input logic busy);
    sb.push_back('{tag: tag, due: due, row: row, busy: busy});
  endtask

  task automatic send(input logic make, input logic ext, input logic [7:0] code);
    ps2_key = {~ps2_key[10], make, ext, code};
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    tick();
    check("drain_timeout", 8'(sb.size()), 8'd0);
    sb.delete();
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  int k, b;

  initial begin
    // 1: reset state under every single-column scan
    reset_dut();
    for (int i = 0; i < 16; i++) begin
      col_sel = ~(16'h0001 << i);
      expect_at("t1_sweep", cyc + 1, 6'h3F, 1'b0);
      tick();
    end
    drain(20);

    // 2: make latency and column selection
    reset_dut();
    col_sel = 16'hFFFB;
    k = cyc;
    send(1'b1, 1'b0, 8'h1C);
    expect_at("t2_early", k + 3, 6'h3F, 1'b0);
    expect_at("t2_make",  k + 4, 6'h37, 1'b0);
    wait_cyc(k + 8);
    col_sel = 16'hFFFE;
    expect_at("t2_othercol", cyc + 1, 6'h3F, 1'b0);
    drain(20);

    // 3: short tap is held until the timer expires
    reset_dut();
    col_sel = 16'hFFFB;
    k = cyc;
    send(1'b1, 1'b0, 8'h1C);
    expect_at("t3_make", k + 4, 6'h37, 1'b0);
    wait_cyc(k + 100);
    send(1'b0, 1'b0, 8'h1C);
    expect_at("t3_pend",     k + 103,  6'h37, 1'b1);
    expect_at("t3_preexp",   k + 1002, 6'h37, 1'b1);
    expect_at("t3_expire",   k + 1003, 6'h37, 1'b0);
    expect_at("t3_released", k + 1004, 6'h3F, 1'b0);
    drain(1100);

    // 4: two columns scanned together; late breaks act at once
    reset_dut();
    col_sel = 16'h0000;
    k = cyc;
    send(1'b1, 1'b0, 8'h1C);
    tick();
    send(1'b1, 1'b0, 8'h1E);
    expect_at("t4_first", k + 4, 6'h37, 1'b0);
    expect_at("t4_both",  k + 5, 6'h35, 1'b0);
    wait_cyc(k + 2000);
    b = cyc;
    send(1'b0, 1'b0, 8'h1C);
    tick();
    send(1'b0, 1'b0, 8'h1E);
    expect_at("t4_brk_lat", b + 3, 6'h35, 1'b0);
    expect_at("t4_brk1",    b + 4, 6'h3D, 1'b0);
    expect_at("t4_brk2",    b + 5, 6'h3F, 1'b0);
    drain(2100);

    // 5: unmapped codes are dropped; repeat make does not reload the timer
    reset_dut();
    col_sel = 16'hFFFB;
    k = cyc;
    send(1'b1, 1'b0, 8'h1C);
    expect_at("t5_make", k + 4, 6'h37, 1'b0);
    wait_cyc(k + 10);
    send(1'b1, 1'b0, 8'h00);
    tick();
    send(1'b0, 1'b1, 8'h1C);
    expect_at("t5_unmapped", k + 15, 6'h37, 1'b0);
    wait_cyc(k + 500);
    send(1'b1, 1'b0, 8'h1C);
    expect_at("t5_repeat", k + 504, 6'h37, 1'b0);
    wait_cyc(k + 600);
    send(1'b0, 1'b0, 8'h1C);
    expect_at("t5_pend",     k + 603,  6'h37, 1'b1);
    expect_at("t5_preexp",   k + 1002, 6'h37, 1'b1);
    expect_at("t5_expire",   k + 1003, 6'h37, 1'b0);
    expect_at("t5_released", k + 1004, 6'h3F, 1'b0);
    drain(1100);

    // 6: reset discards a pending release and an event toggled during reset
    reset_dut();
    col_sel = 16'hFFF3;
    k = cyc;
    send(1'b1, 1'b0, 8'h1C);
    expect_at("t6_make", k + 4, 6'h37, 1'b0);
    wait_cyc(k + 100);
    send(1'b0, 1'b0, 8'h1C);
    expect_at("t6_pend", k + 104, 6'h37, 1'b1);
    wait_cyc(k + 200);
    reset = 1'b1;
    send(1'b1, 1'b0, 8'h1E);
    expect_at("t6_after_rst", k + 201, 6'h3F, 1'b0);
    expect_at("t6_lost_evt",  k + 206, 6'h3F, 1'b0);
    tick();
    reset = 1'b0;
    wait_cyc(k + 300);
    send(1'b1, 1'b0, 8'h1E);
    expect_at("t6_new_make", k + 304,  6'h3D, 1'b0);
    expect_at("t6_no_late",  k + 1010, 6'h3D, 1'b0);
    drain(1100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
